// File: rtl/model_integration_scheduler_pkg.sv
// Shared NTM math constants and the integration scheduler state encoding.
// Imported by the scheduler and its arithmetic interface.
package model_integration_scheduler_pkg;

    localparam int DATA_SIZE_DEF    = 64;
    localparam int CONTROL_SIZE_DEF = 4;

    localparam logic [DATA_SIZE_DEF-1:0]    ZERO_DATA    = '0;
    localparam logic [DATA_SIZE_DEF-1:0]    ONE_DATA     = 64'd1;
    localparam logic [CONTROL_SIZE_DEF-1:0] ZERO_CONTROL = '0;

    typedef enum logic [2:0] {
        IDLE_ST      = 3'd0,
        INPUT_ST     = 3'd1,
        ADD_WAIT_ST  = 3'd2,
        MULT_WAIT_ST = 3'd3,
        ENDER_ST     = 3'd4
    } sched_state_t;

endpackage

// File: rtl/model_integration_scheduler_if.sv
// Handshake and operand bundle between the scheduler and the shared
// float adder / multiplier owned by the parent.
interface model_integration_scheduler_if #(
    parameter int DATA_SIZE = 64
) ();
    import model_integration_scheduler_pkg::*;

    logic                 adder_start;
    logic                 adder_ready;
    logic                 adder_operation;
    logic [DATA_SIZE-1:0] adder_data_a;
    logic [DATA_SIZE-1:0] adder_data_b;
    logic [DATA_SIZE-1:0] adder_data_out;

    logic                 mult_start;
    logic                 mult_ready;
    logic [DATA_SIZE-1:0] mult_data_a;
    logic [DATA_SIZE-1:0] mult_data_b;
    logic [DATA_SIZE-1:0] mult_data_out;

    modport master (
        output adder_start, adder_operation, adder_data_a, adder_data_b,
        output mult_start, mult_data_a, mult_data_b,
        input  adder_ready, adder_data_out,
        input  mult_ready, mult_data_out
    );

    modport slave (
        input  adder_start, adder_operation, adder_data_a, adder_data_b,
        input  mult_start, mult_data_a, mult_data_b,
        output adder_ready, adder_data_out,
        output mult_ready, mult_data_out
    );

endinterface

// File: rtl/model_integration_scheduler.sv
// Integrates a stream of N float samples: result = h * sum(samples),
// using the parent's shared adder and multiplier.
module model_integration_scheduler
    import model_integration_scheduler_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    output logic                 ready_o,
    input  logic [DATA_SIZE-1:0] length_i,
    input  logic [DATA_SIZE-1:0] period_i,
    input  logic [DATA_SIZE-1:0] data_i,
    input  logic                 data_in_enable_i,
    output logic                 data_enable_o,
    output logic [DATA_SIZE-1:0] data_o,
    model_integration_scheduler_if.master arith
);

    localparam logic [DATA_SIZE-1:0]    ZD     = DATA_SIZE'(ZERO_DATA);
    localparam logic [CONTROL_SIZE-1:0] OP_ADD = CONTROL_SIZE'(ZERO_CONTROL);

    sched_state_t         state_q;
    logic [DATA_SIZE-1:0] len_q;
    logic [DATA_SIZE-1:0] h_q;
    logic [DATA_SIZE-1:0] acc_q;
    logic [DATA_SIZE-1:0] cnt_q;
    logic [DATA_SIZE-1:0] cnt_d;
    logic [DATA_SIZE-1:0] data_q;
    logic [DATA_SIZE-1:0] add_a_q;
    logic [DATA_SIZE-1:0] add_b_q;
    logic [DATA_SIZE-1:0] mult_a_q;
    logic [DATA_SIZE-1:0] mult_b_q;
    logic                 ready_q;
    logic                 de_q;
    logic                 add_start_q;
    logic                 mult_start_q;

    assign cnt_d = cnt_q + DATA_SIZE'(1);

    // Sequencer: one sample per adder pass, then a single scale by h.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE_ST;
            len_q        <= ZD;
            h_q          <= ZD;
            acc_q        <= ZD;
            cnt_q        <= ZD;
            data_q       <= ZD;
            add_a_q      <= ZD;
            add_b_q      <= ZD;
            mult_a_q     <= ZD;
            mult_b_q     <= ZD;
            ready_q      <= 1'b0;
            de_q         <= 1'b0;
            add_start_q  <= 1'b0;
            mult_start_q <= 1'b0;
        end else begin
            ready_q      <= 1'b0;
            add_start_q  <= 1'b0;
            mult_start_q <= 1'b0;
            unique case (state_q)
                IDLE_ST: begin
                    if (start_i) begin
                        len_q <= length_i;
                        h_q   <= period_i;
                        acc_q <= ZD;
                        cnt_q <= ZD;
                        if (length_i == ZD) begin
                            data_q  <= ZD;
                            state_q <= ENDER_ST;
                        end else begin
                            de_q    <= 1'b1;
                            state_q <= INPUT_ST;
                        end
                    end
                end
                INPUT_ST: begin
                    if (data_in_enable_i) begin
                        add_a_q     <= acc_q;
                        add_b_q     <= data_i;
                        add_start_q <= 1'b1;
                        de_q        <= 1'b0;
                        state_q     <= ADD_WAIT_ST;
                    end
                end
                ADD_WAIT_ST: begin
                    if (arith.adder_ready) begin
                        acc_q <= arith.adder_data_out;
                        cnt_q <= cnt_d;
                        if (cnt_d == len_q) begin
                            mult_a_q     <= arith.adder_data_out;
                            mult_b_q     <= h_q;
                            mult_start_q <= 1'b1;
                            state_q      <= MULT_WAIT_ST;
                        end else begin
                            de_q    <= 1'b1;
                            state_q <= INPUT_ST;
                        end
                    end
                end
                MULT_WAIT_ST: begin
                    if (arith.mult_ready) begin
                        data_q  <= arith.mult_data_out;
                        state_q <= ENDER_ST;
                    end
                end
                ENDER_ST: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE_ST;
                end
                default: begin
                    state_q <= IDLE_ST;
                end
            endcase
        end
    end

    assign ready_o               = ready_q;
    assign data_enable_o         = de_q;
    assign data_o                = data_q;
    assign arith.adder_start     = add_start_q;
    assign arith.adder_operation = OP_ADD[0];
    assign arith.adder_data_a    = add_a_q;
    assign arith.adder_data_b    = add_b_q;
    assign arith.mult_start      = mult_start_q;
    assign arith.mult_data_a     = mult_a_q;
    assign arith.mult_data_b     = mult_b_q;

endmodule

// File: tb/tb_model_integration_scheduler.sv
// Randomised bench for the integration scheduler with an integer
// adder/multiplier stand-in and a transaction-level reference model.
module tb_model_integration_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        ready;
    logic [63:0] len;
    logic [63:0] per;
    logic [63:0] din;
    logic        die;
    logic        de;
    logic [63:0] dout;

    model_integration_scheduler_if #(.DATA_SIZE(64)) arith ();

    model_integration_scheduler #(
        .DATA_SIZE(64),
        .CONTROL_SIZE(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start_i(start),
        .ready_o(ready),
        .length_i(len),
        .period_i(per),
        .data_i(din),
        .data_in_enable_i(die),
        .data_enable_o(de),
        .data_o(dout),
        .arith(arith.master)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;

    // reference model state
    bit          active, de_exp, add_busy, mult_busy;
    longint      n_m, h_m, sum_m, acc_cnt, de_cycles, start_cyc;
    longint      exp_ready, add_start_cyc, mult_start_cyc;
    logic [63:0] op_a, op_b, exp_out;

    // observation counters
    int     n_add = 0, n_mult = 0, n_ready = 0;
    bit     got_ready;
    longint ready_cyc = -1;

    // arithmetic stand-in state
    int          add_cd = 0, mul_cd = 0;
    logic [63:0] add_res, mul_res;
    bit          strays = 0;

    logic [63:0] smp[16];
    int          gp[16];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s cyc=%0d timeout", name, cyc);
    endtask

    task automatic reset_model();
        active = 0; de_exp = 0; add_busy = 0; mult_busy = 0;
        n_m = 0; h_m = 0; sum_m = 0; acc_cnt = 0; de_cycles = 0;
        start_cyc = -1; exp_ready = -1;
        add_start_cyc = -1; mult_start_cyc = -1;
        op_a = '0; op_b = '0; exp_out = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        // fold in what was presented during the previous cycle
        if (!rst_n) begin
            reset_model();
        end else if (!active) begin
            if (start) begin
                active = 1; n_m = longint'(len); h_m = longint'(per);
                sum_m = 0; acc_cnt = 0; de_cycles = 0;
                start_cyc = cyc - 1;
                if (len == 0) begin
                    exp_ready = cyc + 1;
                    exp_out   = '0;
                end else begin
                    de_exp = 1;
                end
            end
        end else if (de_exp) begin
            de_cycles++;
            if (die) begin
                op_a = sum_m; op_b = din;
                add_busy = 1; de_exp = 0;
                add_start_cyc = cyc;
            end
        end else if (add_busy) begin
            if (arith.adder_ready) begin
                sum_m += longint'(op_b);
                acc_cnt++;
                add_busy = 0;
                if (acc_cnt == n_m) begin
                    mult_busy = 1;
                    mult_start_cyc = cyc;
                    exp_ready = start_cyc + de_cycles + 3 * n_m + 5;
                end else begin
                    de_exp = 1;
                end
            end
        end else if (mult_busy) begin
            if (arith.mult_ready) begin
                mult_busy = 0;
                exp_out = h_m * sum_m;
            end
        end
        // compare this cycle's outputs
        if (!rst_n) begin
            chk("rst_ready", ready, 1'b0);
            chk("rst_de", de, 1'b0);
            chk("rst_astart", arith.adder_start, 1'b0);
            chk("rst_mstart", arith.mult_start, 1'b0);
            chk("rst_aop", arith.adder_operation, 1'b0);
            chk("rst_dout", dout, 64'd0);
            chk("rst_aa", arith.adder_data_a, 64'd0);
            chk("rst_ab", arith.adder_data_b, 64'd0);
            chk("rst_ma", arith.mult_data_a, 64'd0);
            chk("rst_mb", arith.mult_data_b, 64'd0);
        end else begin
            chk("de", de, de_exp);
            chk("astart", arith.adder_start, cyc == add_start_cyc);
            chk("mstart", arith.mult_start, cyc == mult_start_cyc);
            chk("ready", ready, cyc == exp_ready);
            chk("dout", dout, exp_out);
            chk("aop", arith.adder_operation, 1'b0);
            if (add_busy) begin
                chk("add_a", arith.adder_data_a, op_a);
                chk("add_b", arith.adder_data_b, op_b);
            end
            if (mult_busy) begin
                chk("mul_a", arith.mult_data_a, sum_m);
                chk("mul_b", arith.mult_data_b, h_m);
            end
        end
        if (arith.adder_start) n_add++;
        if (arith.mult_start) n_mult++;
        got_ready = ready;
        if (ready) begin
            n_ready++;
            ready_cyc = cyc;
        end
        if (cyc == exp_ready) begin
            active = 0;
            exp_ready = -1;
        end
        // arithmetic stand-in: 3 cycles in the wait state
        arith.adder_ready = 1'b0;
        arith.mult_ready  = 1'b0;
        if (add_cd > 0) begin
            add_cd--;
            if (add_cd == 0) begin
                arith.adder_ready    = 1'b1;
                arith.adder_data_out = add_res;
            end
        end
        if (mul_cd > 0) begin
            mul_cd--;
            if (mul_cd == 0) begin
                arith.mult_ready    = 1'b1;
                arith.mult_data_out = mul_res;
            end
        end
        if (arith.adder_start) begin
            add_cd  = 2;
            add_res = arith.adder_data_a + arith.adder_data_b;
        end
        if (arith.mult_start) begin
            mul_cd  = 2;
            mul_res = arith.mult_data_a * arith.mult_data_b;
        end
        if (strays) begin
            if (!add_busy && add_cd == 0 && $urandom_range(7) == 0) begin
                arith.adder_ready    = 1'b1;
                arith.adder_data_out = {$urandom, $urandom};
            end
            if (!mult_busy && mul_cd == 0 && $urandom_range(7) == 0) begin
                arith.mult_ready    = 1'b1;
                arith.mult_data_out = {$urandom, $urandom};
            end
        end
        start = 1'b0;
        die   = 1'b0;
    endtask

    task automatic wait_de(output bit ok);
        ok = 0;
        for (int k = 0; k < 64; k++) begin
            if (de) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) fail_now("wait_de");
    endtask

    task automatic wait_ready();
        bit ok;
        ok = 0;
        for (int k = 0; k < 96; k++) begin
            if (got_ready) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) fail_now("wait_ready");
    endtask

    task automatic run_job(input int n, input longint h,
                           input bit mid_start, input bit junk);
        bit ok;
        len   = 64'(n);
        per   = 64'(h);
        start = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            wait_de(ok);
            if (!ok) return;
            repeat (gp[i]) tick();
            die = 1'b1;
            din = smp[i];
            tick();
            if (junk) begin
                die = 1'b1;
                din = {$urandom, $urandom};
            end
            if (mid_start && i == 0) begin
                start = 1'b1;
                len   = 64'($urandom_range(9));
                per   = 64'($urandom_range(99));
            end
        end
        wait_ready();
    endtask

    initial begin
        int a0, m0, r0;
        longint sc;
        bit ok;
        rst_n = 1'b0; start = 1'b0; die = 1'b0;
        len = '0; per = '0; din = '0;
        arith.adder_ready = 1'b0; arith.mult_ready = 1'b0;
        arith.adder_data_out = '0; arith.mult_data_out = '0;
        reset_model();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("init_ready", ready, 1'b0);
        chk("init_de", de, 1'b0);
        chk("init_dout", dout, 64'd0);

        // four samples, enable one cycle after each DATA_ENABLE
        smp[0] = 1; smp[1] = 2; smp[2] = 3; smp[3] = 4;
        for (int i = 0; i < 16; i++) gp[i] = 1;
        a0 = n_add; m0 = n_mult; r0 = n_ready;
        run_job(4, 2, 0, 0);
        chk("t1_dout", dout, 64'd20);
        chk("t1_adds", 64'(n_add - a0), 64'd4);
        chk("t1_mults", 64'(n_mult - m0), 64'd1);
        repeat (3) tick();
        chk("t1_readys", 64'(n_ready - r0), 64'd1);

        // empty integration
        a0 = n_add; m0 = n_mult;
        len = 0; per = 64'd9; start = 1'b1;
        sc = cyc;
        tick();
        tick();
        chk("n0_ready", got_ready, 1'b1);
        chk("n0_lat", 64'(ready_cyc - sc), 64'd2);
        chk("n0_dout", dout, 64'd0);
        chk("n0_starts", 64'(n_add - a0 + n_mult - m0), 64'd0);
        repeat (2) tick();

        // gap before sample 2 and a restart attempt mid-run
        smp[0] = 5; smp[1] = 6; smp[2] = 7;
        gp[0] = 0; gp[1] = 5; gp[2] = 0;
        r0 = n_ready;
        run_job(3, 4, 1, 0);
        chk("t3_dout", dout, 64'd72);
        repeat (3) tick();
        chk("t3_readys", 64'(n_ready - r0), 64'd1);

        // enable strobes during the add wait must be dropped
        smp[0] = 10; smp[1] = 20;
        gp[0] = 0; gp[1] = 2;
        run_job(2, 1, 0, 1);
        chk("t4_dout", dout, 64'd30);
        repeat (2) tick();

        // reset in the add wait of sample 2, then a late adder ready
        smp[0] = 1; smp[1] = 2;
        len = 3; per = 2; start = 1'b1;
        tick();
        wait_de(ok);
        die = 1'b1; din = smp[0];
        tick();
        wait_de(ok);
        die = 1'b1; din = smp[1];
        tick();
        chk("t5_astart", arith.adder_start, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_astart", arith.adder_start, 1'b0);
        chk("t5_async_dout", dout, 64'd0);
        r0 = n_ready;
        tick();
        rst_n = 1'b1;
        repeat (8) tick();
        chk("t5_noready", 64'(n_ready - r0), 64'd0);
        chk("t5_dout", dout, 64'd0);
        chk("t5_de", de, 1'b0);
        smp[0] = 7; gp[0] = 1;
        run_job(1, 3, 0, 0);
        chk("t5_dout21", dout, 64'd21);
        repeat (2) tick();

        // randomised jobs with stray strobes and readies
        strays = 1;
        for (int j = 0; j < 30; j++) begin
            int n;
            n = $urandom_range(6, 1);
            for (int i = 0; i < 16; i++) begin
                smp[i] = 64'($urandom_range(65535));
                gp[i]  = $urandom_range(3);
            end
            run_job(n, longint'($urandom_range(1000, 1)),
                    bit'($urandom_range(1)), bit'($urandom_range(1)));
            repeat ($urandom_range(3)) tick();
        end
        strays = 0;
        repeat (6) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/model_integration_scheduler.md
MODEL_INTEGRATION_SCHEDULER -- requirements
Module: model_integration_scheduler

Interface
REQ-001 Parameter DATA_SIZE, default 64, SHALL set the width of data, length, period and sample-count registers.
REQ-002 Parameter CONTROL_SIZE, default 4, SHALL be passed through for consistency with the scalar float units; it has no internal use.
REQ-003 CLK  in  1  single clock; every flop SHALL be rising-edge.
REQ-004 RST  in  1  reset; it SHALL be asynchronous and active-low.
REQ-005 START  in  1  one-cycle pulse that begins an integration.
REQ-006 READY  out  1  one-cycle pulse marking DATA_OUT valid.
REQ-007 LENGTH_IN  in  DATA_SIZE  sample count N, captured on START.
REQ-008 PERIOD_IN  in  DATA_SIZE  float step h, captured on START.
REQ-009 DATA_IN  in  DATA_SIZE  float sample.
REQ-010 DATA_IN_ENABLE  in  1  DATA_IN valid strobe.
REQ-011 DATA_ENABLE  out  1  high while the block accepts a sample.
REQ-012 DATA_OUT  out  DATA_SIZE  result h*sum(samples).
REQ-013 ADDER_START  out  1  one-cycle start pulse to the shared float adder.
REQ-014 ADDER_READY  in  1  adder completion pulse.
REQ-015 ADDER_OPERATION  out  1  add/subtract select; it SHALL be held at 0 (add).
REQ-016 ADDER_DATA_A / ADDER_DATA_B  out  DATA_SIZE each  adder operands.
REQ-017 ADDER_DATA_OUT  in  DATA_SIZE  adder result.
REQ-018 MULT_START  out  1  one-cycle start pulse to the shared float multiplier.
REQ-019 MULT_READY  in  1  multiplier completion pulse.
REQ-020 MULT_DATA_A / MULT_DATA_B  out  DATA_SIZE each  multiplier operands.
REQ-021 MULT_DATA_OUT  in  DATA_SIZE  multiplier result.

Function
REQ-022 The FSM SHALL have the states IDLE, INPUT, ADD_WAIT, MULT_WAIT and ENDER.
REQ-023 IDLE: on START, the block SHALL capture LENGTH_IN and PERIOD_IN, clear the accumulator to ZERO_DATA and the counter to 0.
- If N = 0, it SHALL go to ENDER.
- Otherwise it SHALL go to INPUT.
REQ-024 INPUT: DATA_ENABLE SHALL be 1.
- On DATA_IN_ENABLE, the block SHALL drive ADDER_DATA_A = accumulator and ADDER_DATA_B = DATA_IN.
- It SHALL pulse ADDER_START for exactly one cycle and go to ADD_WAIT.
REQ-025 ADD_WAIT: DATA_ENABLE SHALL be 0 and ADDER_DATA_A/B SHALL be held stable.
- On ADDER_READY, the accumulator SHALL load ADDER_DATA_OUT and the counter SHALL increment.
- If counter+1 = N: operands SHALL be driven to MULT_DATA_A = accumulator result and MULT_DATA_B = h, MULT_START SHALL pulse once, and the FSM SHALL go to MULT_WAIT.
- Else the FSM SHALL return to INPUT.
REQ-026 MULT_WAIT: on MULT_READY, DATA_OUT SHALL load MULT_DATA_OUT and the FSM SHALL go to ENDER.
REQ-027 ENDER: READY SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE.
- For N = 0, DATA_OUT SHALL be ZERO_DATA.
REQ-028 DATA_OUT SHALL hold its value until the next result is loaded.
REQ-029 START outside IDLE SHALL be ignored.
REQ-030 DATA_IN_ENABLE outside INPUT SHALL be ignored (no buffering).
REQ-031 Stray ADDER_READY or MULT_READY received outside the matching wait state SHALL be ignored.
REQ-032 Latency from START to READY SHALL equal the sum over all samples of (input wait + 1 + adder latency), plus multiplier latency, plus 2 cycles; for N = 0 it SHALL be 2 cycles.
REQ-033 The counter SHALL be DATA_SIZE wide and compare unsigned; wrap-around SHALL NOT occur because N < 2^DATA_SIZE.

Reset
REQ-034 While RST = 0, the state SHALL be IDLE and READY, DATA_ENABLE, ADDER_START, MULT_START, ADDER_OPERATION SHALL be 0.
REQ-035 While RST = 0, DATA_OUT, the accumulator, the counter, the captured N and h, and all operand outputs SHALL be ZERO_DATA.
REQ-036 Reset asserted mid-operation SHALL abort immediately.
- No READY SHALL follow the abort.
- A late ADDER_READY or MULT_READY arriving after release SHALL be ignored.

Structure
REQ-037 The FSM state encoding and ZERO_DATA/ONE_DATA/ZERO_CONTROL SHALL reside in the shared NTM math package.
REQ-038 The block SHALL be a single module with no sub-modules.
- The scalar float adder and multiplier SHALL be instantiated by the parent and wired to the ADDER_*/MULT_* ports.

Verification
REQ-039 The bench SHALL model the adder and multiplier as integer add and multiply with 3-cycle latency.
REQ-040 N = 4, h = 2, samples 1, 2, 3, 4 with DATA_IN_ENABLE on the cycle after each DATA_ENABLE -> DATA_OUT = 20, exactly four ADDER_START pulses, one MULT_START pulse, one READY pulse.
REQ-041 N = 0 -> READY 2 cycles after START, DATA_OUT = 0, no ADDER_START or MULT_START pulse.
REQ-042 N = 3 with a 5-cycle gap before sample 2, and START re-pulsed mid-run -> result h*sum correct, second START ignored.
REQ-043 RST low during ADD_WAIT of sample 2, then a late ADDER_READY -> IDLE, outputs at reset values, no READY; a following N = 1, h = 3, sample 7 run -> DATA_OUT = 21.
REQ-044 DATA_IN_ENABLE asserted during ADD_WAIT -> sample ignored, accumulator unchanged.
